// File: rtl/fnd_scan_driver_if.sv
// Display-side bundle for the FND scan driver: frame inputs (digit codes, dp, blink) and
// registered segment/common/frame outputs. No handshake; inputs are sampled once per frame.
interface fnd_scan_driver_if;
   logic [3:0] i_digit0;
   logic [3:0] i_digit1;
   logic [3:0] i_digit2;
   logic [3:0] i_digit3;
   logic [3:0] i_dp;
   logic [3:0] i_blink;
   logic [7:0] o_seg;
   logic [3:0] o_com;
   logic       o_frame;

   modport master (
      output i_digit0, i_digit1, i_digit2, i_digit3, i_dp, i_blink,
      input  o_seg, o_com, o_frame
   );

   modport slave (
      input  i_digit0, i_digit1, i_digit2, i_digit3, i_dp, i_blink,
      output o_seg, o_com, o_frame
   );
endinterface

// File: rtl/fnd_scan_driver.sv
// 4-digit time-multiplexed FND driver: BLANK/SHOW scan, frame latch, per-digit dp and blink.
// Outputs registered (one cycle behind state decisions); no backpressure, inputs sampled once per frame.
module fnd_scan_driver #(
   parameter int DWELL        = 50000,
   parameter int DEAD         = 16,
   parameter int BLINK_FRAMES = 250,
   parameter bit SEG_ACT_LOW  = 1'b1,
   parameter bit COM_ACT_LOW  = 1'b1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   fnd_scan_driver_if.slave   bus
);

   localparam int CMAX = (DWELL > DEAD) ? DWELL : DEAD;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int FW   = $clog2(BLINK_FRAMES + 1);
   localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD - 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
   localparam logic [FW-1:0] FRM_LAST   = FW'(BLINK_FRAMES - 1);
   localparam logic [7:0]    SEG_OFF    = SEG_ACT_LOW ? 8'hFF : 8'h00;
   localparam logic [3:0]    COM_OFF    = COM_ACT_LOW ? 4'hF : 4'h0;

   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

   function automatic logic [6:0] decode(input logic [3:0] code);
      logic [6:0] pat;
      case (code)
         4'd0:    pat = 7'h3F;
         4'd1:    pat = 7'h06;
         4'd2:    pat = 7'h5B;
         4'd3:    pat = 7'h4F;
         4'd4:    pat = 7'h66;
         4'd5:    pat = 7'h6D;
         4'd6:    pat = 7'h7D;
         4'd7:    pat = 7'h07;
         4'd8:    pat = 7'h7F;
         4'd9:    pat = 7'h6F;
         4'd11:   pat = 7'h40;
         default: pat = 7'h00;
      endcase
      return pat;
   endfunction

   state_t          state_q, state_d;
   logic [1:0]      idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [FW-1:0]   frm_cnt_q, frm_cnt_d;
   logic            phase_q, phase_d;
   logic [3:0][3:0] code_q, code_d;
   logic [3:0]      dp_q, dp_d;
   logic [3:0]      mask_q, mask_d;
   logic [7:0]      seg_q, seg_d;
   logic [3:0]      com_q, com_d;
   logic            frame_q, frame_d;
   logic            latch;
   logic [7:0]      seg_hi;
   logic [3:0]      com_hi;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q + CW'(1);
      frm_cnt_d = frm_cnt_q;
      phase_d   = phase_q;
      code_d    = code_q;
      dp_d      = dp_q;
      mask_d    = mask_q;
      seg_hi    = 8'h00;
      com_hi    = 4'h0;
      seg_d     = SEG_OFF;
      com_d     = COM_OFF;

      latch   = (state_q == ST_BLANK) && (idx_q == 2'd0) && (cnt_q == '0);
      frame_d = latch;

      case (state_q)
         ST_BLANK: if (cnt_q == DEAD_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
         end
         ST_SHOW: if (cnt_q == DWELL_LAST) begin
            state_d = ST_BLANK;
            idx_d   = idx_q + 2'd1;
            cnt_d   = '0;
         end
         default: state_d = ST_BLANK;
      endcase

      // The frame uses the blink phase as it stood before this latch, so a
      // phase holds for BLINK_FRAMES whole frames starting at frame 0.
      if (latch) begin
         code_d = {bus.i_digit3, bus.i_digit2, bus.i_digit1, bus.i_digit0};
         dp_d   = bus.i_dp;
         mask_d = phase_q ? bus.i_blink : 4'h0;
         if (frm_cnt_q == FRM_LAST) begin
            frm_cnt_d = '0;
            phase_d   = ~phase_q;
         end else begin
            frm_cnt_d = frm_cnt_q + FW'(1);
         end
      end

      // Outputs are computed from next-state values so the registered pins line up with state_q.
      if (state_d == ST_SHOW) begin
         seg_hi = {dp_d[idx_d], decode(code_d[idx_d])};
         if (mask_d[idx_d]) seg_hi = 8'h00;
         com_hi = 4'b0001 << idx_d;
         seg_d  = SEG_ACT_LOW ? ~seg_hi : seg_hi;
         com_d  = COM_ACT_LOW ? ~com_hi : com_hi;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_BLANK;
         idx_q     <= 2'd0;
         cnt_q     <= '0;
         frm_cnt_q <= '0;
         phase_q   <= 1'b0;
         code_q    <= {4{4'd10}};
         dp_q      <= 4'h0;
         mask_q    <= 4'h0;
         seg_q     <= SEG_OFF;
         com_q     <= COM_OFF;
         frame_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         frm_cnt_q <= frm_cnt_d;
         phase_q   <= phase_d;
         code_q    <= code_d;
         dp_q      <= dp_d;
         mask_q    <= mask_d;
         seg_q     <= seg_d;
         com_q     <= com_d;
         frame_q   <= frame_d;
      end
   end

   assign bus.o_seg   = seg_q;
   assign bus.o_com   = com_q;
   assign bus.o_frame = frame_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Randomized bench for fnd_scan_driver; reference model derives outputs from the cycle
// position inside the frame since the last reset release.
module tb_fnd_scan_driver;
   localparam int DWELL = 4;
   localparam int DEAD  = 2;
   localparam int BF    = 2;
   localparam int SLOT  = DEAD + DWELL;
   localparam int FP    = 4 * SLOT;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fnd_scan_driver_if bus();

   fnd_scan_driver #(
      .DWELL(DWELL), .DEAD(DEAD), .BLINK_FRAMES(BF),
      .SEG_ACT_LOW(1'b1), .COM_ACT_LOW(1'b1)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Active-high {g..a} patterns for codes 0..15.
   logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h00, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00};

   int         k = -1;
   logic [3:0] m_code [4];
   logic [3:0] m_dp;
   logic [3:0] m_mask;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s k=%0d got=%h want=%h @%0t", tag, k, obs, exp_v, $time);
      end
   endtask

   // Advance one clock: update the model from what is being driven, then compare after the edge.
   task automatic tick();
      logic [7:0] es;
      logic [3:0] ec;
      logic       ef;
      int q, s, o, n;
      es = 8'hFF;
      ec = 4'hF;
      ef = 1'b0;
      if (rst) begin
         k = -1;
      end else begin
         k++;
         ef = (k % FP == 0);
         if (ef) begin
            m_code[0] = bus.i_digit0;
            m_code[1] = bus.i_digit1;
            m_code[2] = bus.i_digit2;
            m_code[3] = bus.i_digit3;
            m_dp      = bus.i_dp;
            n         = k / FP;
            m_mask    = (((n / BF) % 2) == 1) ? bus.i_blink : 4'h0;
         end
         q = (k + 1) % FP;
         s = q / SLOT;
         o = q % SLOT;
         if (o >= DEAD) begin
            ec = ~(4'(1) << s);
            es = m_mask[s] ? 8'hFF : ~{m_dp[s], tbl[m_code[s]]};
         end
      end
      @(posedge clk);
      #1;
      chk("seg", bus.o_seg, es);
      chk("com", {4'h0, bus.o_com}, {4'h0, ec});
      chk("frame", {7'h0, bus.o_frame}, {7'h0, ef});
   endtask

   task automatic set_in(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                         input logic [3:0] d0, input logic [3:0] dp, input logic [3:0] bl);
      bus.i_digit3 = d3;
      bus.i_digit2 = d2;
      bus.i_digit1 = d1;
      bus.i_digit0 = d0;
      bus.i_dp     = dp;
      bus.i_blink  = bl;
   endtask

   task automatic rand_in();
      set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom));
   endtask

   initial begin
      set_in(4'd0, 4'd9, 4'd1, 4'd7, 4'h0, 4'h0);
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      // Known frame, then a mid-frame change of digit 0 that must wait for the next latch.
      for (int i = 0; i < 2 * FP; i++) begin
         if (i == 15) bus.i_digit0 = 4'd3;
         tick();
      end

      // Special codes, dp, and blink on digit 0 across several blink half-periods.
      set_in(4'd14, 4'd8, 4'd11, 4'd5, 4'b0100, 4'b0001);
      for (int i = 0; i < 6 * FP; i++) tick();

      // Reset during digit 2 SHOW, then restart with fresh inputs.
      while (!(k % FP >= 2 * SLOT + DEAD && k % FP < 3 * SLOT - 1)) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_in(4'd1, 4'd2, 4'd3, 4'd4, 4'b1010, 4'hF);
      for (int i = 0; i < 5 * FP; i++) tick();

      // Randomized segments: inputs churn every cycle, random-length runs split by resets.
      for (int seg = 0; seg < 30; seg++) begin
         int len;
         len = $urandom_range(1, 160);
         for (int i = 0; i < len; i++) begin
            rand_in();
            tick();
         end
         rst = 1'b1;
         for (int i = 0; i < $urandom_range(1, 3); i++) begin
            rand_in();
            tick();
         end
         rst = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fnd_scan_driver.md
Name: fnd_scan_driver

Overview:
Time-multiplexed driver for the 4-digit common-cathode/anode FND on the Snake Game board. It consumes 4-bit digit codes from the speed/score digit encoders (0-9 numeral, 10 blank) and drives one digit at a time. The driver latches a coherent frame of inputs, inserts a ghost-suppression gap between digits, and supports per-digit decimal point and blink.

Parameters:
DWELL, 50000, clock cycles each digit is lit (SHOW state), >=1
DEAD, 16, all-off cycles before each digit (BLANK state), >=1
BLINK_FRAMES, 250, frames per blink half-period, >=1
SEG_ACT_LOW, 1, 1 = o_seg bits active-low (inverted), 0 = active-high
COM_ACT_LOW, 1, 1 = o_com bits active-low, 0 = active-high

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous reset, active-high
i_digit0  input  4  code for digit 0 (rightmost, ones)
i_digit1  input  4  code for digit 1 (tens)
i_digit2  input  4  code for digit 2
i_digit3  input  4  code for digit 3 (leftmost)
i_dp  input  4  decimal point enable, bit n = digit n
i_blink  input  4  blink enable, bit n = digit n
o_seg  output  8  segments {dp,g,f,e,d,c,b,a}
o_com  output  4  digit commons, bit n = digit n
o_frame  output  1  one-cycle pulse, frame latch taken

Behaviour:
- Reset (i_rst high at edge): state=BLANK, idx=0, cnt=0, frame counter=0, blink phase=0 (visible), latched codes=10, latched dp/blink=0. o_seg and o_com drive all-off (all 1s for active-low, all 0s for active-high). o_frame=0. Reset mid-operation takes effect on the next edge.
- FSM, two states, with cnt counting cycles in the current state:
  - BLANK: lasts DEAD cycles (cnt 0..DEAD-1), then goes to SHOW with cnt=0.
  - SHOW: lasts DWELL cycles, then goes to BLANK, idx=(idx+1) mod 4, cnt=0.
- Frame latch: on any edge with i_rst=0, state=BLANK, idx=0, cnt=0:
  - capture i_digit0..3, i_dp, i_blink;
  - set o_frame=1 for exactly the following cycle.
  - The first latch occurs on the first edge after reset release.
  - Frame period is 4*(DEAD+DWELL) cycles.
  - Input changes between latches have no visible effect.
- Blink:
  - The frame counter increments at each latch.
  - On reaching BLINK_FRAMES-1 it wraps to 0 and toggles the blink phase.
  - Phase 1 blanks every digit whose latched blink bit is 1, including its dp.
- Outputs are registered and reflect the current state/idx.
  - BLANK: o_seg and o_com all-off.
  - SHOW: o_com one-hot on idx; o_seg = decode(latched code[idx]) with bit7 = latched dp[idx].
- Decode, active-high {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - 10 = 00 (blank), 11 = 40 ('-'), 12-15 = 00 (blank)
- Polarity: the active-high pattern is inverted when the corresponding *_ACT_LOW parameter is 1.
- No combinational path from any input to any output.

Test Plan:
Use DWELL=4, DEAD=2, BLINK_FRAMES=2, SEG_ACT_LOW=1, COM_ACT_LOW=1.
1. Hold i_rst for 3 cycles -> o_seg=8'hFF, o_com=4'hF, o_frame=0 throughout. Release -> o_frame high exactly 1 cycle, then repeats every 24 cycles.
2. Digits {3,2,1,0}={0,9,1,7}, dp=0, blink=0 -> 2 cycles all-off, then o_com=4'b1110 with o_seg=8'hF8 for 4 cycles; then 2 off, o_com=4'b1101 with o_seg=8'hF9; then 4'b1011 with 8'h90; then 4'b0111 with 8'hC0.
3. Code 10 -> o_seg=8'hFF while its common is active. Code 11 -> 8'hBF. Code 8 with dp bit set -> 8'h00. Code 14 -> 8'hFF.
4. Change i_digit0 from 7 to 3 mid-frame (during digit 2 SHOW) -> the remainder of the frame is unchanged; digit 0 shows 8'hB0 only after the next o_frame pulse.
5. i_blink=4'b0001, digit0=5 -> digit 0 shows 8'h92 in frames 0-1, all-off (8'hFF, common still cycling) in frames 2-3, visible again in frames 4-5; digits 1-3 are unaffected.
6. Assert i_rst during digit 2 SHOW -> next cycle outputs all-off. After release, the first lit digit is idx 0 using freshly latched inputs, and the blink phase is visible.
